// File: rtl/tree_adder_accum_ctrl.sv
// Chunked reduction sequencer around a shared LANES-wide tree adder.
// Streams chunks in, accumulates tree sums, returns a 32-bit result.

module binary_tree_adder #(
  parameter int LANES = 8,
  parameter int P     = 8,
  localparam int TW   = P + $clog2(LANES)
) (
  input  logic [P-1:0]  data_i [LANES],
  input  logic          signed_i,
  output logic [TW-1:0] sum_o
);

  localparam int EXT = TW - P;

  logic [TW-1:0] v [LANES];

  // Extend leaves to full width, then fold pairs level by level in place
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (signed_i)
        v[i] = {{EXT{data_i[i][P-1]}}, data_i[i]};
      else
        v[i] = {{EXT{1'b0}}, data_i[i]};
    end
    for (int w = LANES / 2; w >= 1; w = w / 2) begin
      for (int j = 0; j < w; j++) begin
        v[j] = v[2*j] + v[2*j+1];
      end
    end
    sum_o = v[0];
  end

endmodule

module tree_adder_accum_ctrl #(
  parameter int LANES = 8,
  parameter int P     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_chunks_i,
  input  logic             signed_i,
  output logic             busy_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [P-1:0]     in_data_i [LANES],
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_sum_o
);

  localparam int TW = P + $clog2(LANES);

  generate
    if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
      $fatal(1, "LANES must be a power of 2 and >= 2");
    end
    if (TW + CNT_W > 32) begin : g_bad_width
      $fatal(1, "P + clog2(LANES) + CNT_W must not exceed 32");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  state_t state, nstate;

  logic [CNT_W-1:0] cnt;
  logic             sgn;
  logic [TW-1:0]    stage;
  logic             stage_v;
  logic [31:0]      acc;
  logic [TW-1:0]    tree_sum;
  logic [31:0]      stage_ext;
  logic             xfer;

  binary_tree_adder #(
    .LANES (LANES),
    .P     (P)
  ) u_tree (
    .data_i   (in_data_i),
    .signed_i (sgn),
    .sum_o    (tree_sum)
  );

  assign busy_o      = (state != IDLE);
  assign in_ready_o  = (state == ACCUM);
  assign out_valid_o = (state == DONE);
  assign out_sum_o   = (state == DONE) ? acc : '0;
  assign xfer        = in_valid_i & in_ready_o;

  // Widen the staged chunk sum according to the job's signedness
  always_comb begin
    if (sgn)
      stage_ext = {{(32-TW){stage[TW-1]}}, stage};
    else
      stage_ext = {{(32-TW){1'b0}}, stage};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nstate;
  end

  // Next-state decode
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (start_i)
          nstate = (num_chunks_i == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (xfer && cnt == CNT_W'(1))
          nstate = DRAIN;
      end
      DRAIN: begin
        nstate = DONE;
      end
      DONE: begin
        if (out_ready_i)
          nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  // Job config, chunk counter, stage register and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      sgn     <= 1'b0;
      stage   <= '0;
      stage_v <= 1'b0;
      acc     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            cnt     <= num_chunks_i;
            sgn     <= signed_i;
            acc     <= '0;
            stage_v <= 1'b0;
          end
        end
        ACCUM: begin
          if (stage_v)
            acc <= acc + stage_ext;
          if (xfer) begin
            stage   <= tree_sum;
            stage_v <= 1'b1;
            cnt     <= cnt - CNT_W'(1);
          end else begin
            stage_v <= 1'b0;
          end
        end
        DRAIN: begin
          if (stage_v)
            acc <= acc + stage_ext;
          stage_v <= 1'b0;
        end
        DONE: begin
          stage_v <= 1'b0;
        end
        default: begin
          stage_v <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tree_adder_accum_ctrl.sv
// Directed bench for tree_adder_accum_ctrl with LANES=4, P=8.
// Inputs change on negedge; outputs are sampled on negedge.

module tb_tree_adder_accum_ctrl;

  localparam int LANES = 4;
  localparam int P     = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_chunks;
  logic             sgn;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [P-1:0]     in_data [LANES];
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;

  int checks = 0;
  int errors = 0;

  tree_adder_accum_ctrl #(
    .LANES (LANES),
    .P     (P),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .num_chunks_i (num_chunks),
    .signed_i     (sgn),
    .busy_o       (busy),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_sum_o    (out_sum)
  );

  always #5 clk = ~clk;

  task automatic set_data(input logic [7:0] a, b, c, d);
    in_data[0] = a;
    in_data[1] = b;
    in_data[2] = c;
    in_data[3] = d;
  endtask

  task automatic start_job(input int n, input bit s);
    @(negedge clk);
    start      = 1'b1;
    num_chunks = n[15:0];
    sgn        = s;
  endtask

  // Present n chunks; chunk k adds inc*k to every lane. Gaps put junk on the bus.
  task automatic feed(input int n, input logic [7:0] a, b, c, d,
                      input logic [7:0] inc, input bit gaps,
                      output int cyc, output bit ok);
    int k = 0;
    int p = 0;
    logic [7:0] add;
    cyc = 0;
    while (k < n && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (gaps && p[0]) begin
        in_valid = 1'b0;
        set_data(8'h55, 8'h55, 8'h55, 8'h55);
      end else begin
        in_valid = 1'b1;
        add = inc * k[7:0];
        set_data(a + add, b + add, c + add, d + add);
      end
      p++;
      if (in_valid && in_ready)
        k++;
    end
    ok = (k == n);
  endtask

  // Stop driving, sample the drain cycle and the result cycle, then acknowledge.
  task automatic drain(output logic v0, output logic v1,
                       output logic [31:0] s, output logic b_after);
    @(negedge clk);
    in_valid = 1'b0;
    v0 = out_valid;
    @(negedge clk);
    v1 = out_valid;
    s  = out_sum;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    b_after = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_sum !== 32'd0) begin
      errors++; $display("FAIL reset_out_sum: got %0h expected 0", out_sum);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int cyc; bit ok;
    logic v0, v1, b; logic [31:0] s;
    start_job(3, 1'b0);
    feed(3, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 1'b0, cyc, ok);
    checks++;
    if (!ok || cyc != 3) begin
      errors++; $display("FAIL basic_xfer_cycles: got %0d ok=%0d expected 3", cyc, ok);
    end
    drain(v0, v1, s, b);
    checks++;
    if (v0 !== 1'b0) begin
      errors++; $display("FAIL basic_valid_t1: got %b expected 0", v0);
    end
    checks++;
    if (v1 !== 1'b1) begin
      errors++; $display("FAIL basic_valid_t2: got %b expected 1", v1);
    end
    checks++;
    if (s !== 32'd30) begin
      errors++; $display("FAIL basic_sum: got %0d expected 30", s);
    end
    checks++;
    if (b !== 1'b0) begin
      errors++; $display("FAIL basic_busy_after: got %b expected 0", b);
    end
  endtask

  task automatic test_signed;
    int cyc; bit ok;
    logic v0, v1, b; logic [31:0] s;
    start_job(2, 1'b1);
    feed(2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd0, 1'b0, cyc, ok);
    drain(v0, v1, s, b);
    checks++;
    if (!ok || v1 !== 1'b1 || s !== 32'hFFFF_FFF8) begin
      errors++; $display("FAIL signed_sum: got %0h valid=%b expected fffffff8", s, v1);
    end
    start_job(2, 1'b0);
    feed(2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd0, 1'b0, cyc, ok);
    drain(v0, v1, s, b);
    checks++;
    if (!ok || v1 !== 1'b1 || s !== 32'd2040) begin
      errors++; $display("FAIL unsigned_sum: got %0d valid=%b expected 2040", s, v1);
    end
  endtask

  task automatic test_zero;
    start_job(0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd0) begin
      errors++; $display("FAIL zero_result: got valid=%b sum=%0h expected 1/0", out_valid, out_sum);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL zero_in_ready: got %b expected 0", in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL zero_idle: got busy=%b valid=%b expected 0/0", busy, out_valid);
    end
  endtask

  task automatic test_backpressure;
    int cyc; bit ok;
    start_job(4, 1'b0);
    feed(4, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 1'b1, cyc, ok);
    checks++;
    if (!ok || cyc != 7) begin
      errors++; $display("FAIL bp_gap_cycles: got %0d ok=%0d expected 7", cyc, ok);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd64) begin
      errors++; $display("FAIL bp_sum: got valid=%b sum=%0d expected 1/64", out_valid, out_sum);
    end
    for (int i = 0; i < 5; i++) begin
      start      = 1'b1;
      num_chunks = 16'd2;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 32'd64 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b sum=%0d ready=%b expected 1/64/0",
                 i, out_valid, out_sum, in_ready);
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL bp_start_ignored: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit ok;
    logic v0, v1, b; logic [31:0] s;
    start_job(1, 1'b0);
    feed(1, 8'd9, 8'd9, 8'd9, 8'd9, 8'd0, 1'b0, cyc, ok);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd36) begin
      errors++; $display("FAIL b2b_first: got valid=%b sum=%0d expected 1/36", out_valid, out_sum);
    end
    out_ready  = 1'b1;
    start      = 1'b1;
    num_chunks = 16'd1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_handshake_start: got busy=%b expected 0", busy);
    end
    feed(1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 1'b0, cyc, ok);
    drain(v0, v1, s, b);
    checks++;
    if (!ok || v1 !== 1'b1 || s !== 32'd4) begin
      errors++; $display("FAIL b2b_second: got valid=%b sum=%0d expected 1/4", v1, s);
    end
  endtask

  task automatic test_reset_mid;
    int cyc; bit ok;
    logic v0, v1, b; logic [31:0] s;
    start_job(5, 1'b0);
    feed(2, 8'd7, 8'd7, 8'd7, 8'd7, 8'd0, 1'b0, cyc, ok);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_pre_reset: got busy=%b ready=%b expected 1/1", busy, in_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 32'd0) begin
      errors++;
      $display("FAIL mid_async_reset: got busy=%b ready=%b valid=%b sum=%0h expected all 0",
               busy, in_ready, out_valid, out_sum);
    end
    @(negedge clk);
    rst = 1'b0;
    start_job(1, 1'b0);
    feed(1, 8'd5, 8'd5, 8'd5, 8'd5, 8'd0, 1'b0, cyc, ok);
    drain(v0, v1, s, b);
    checks++;
    if (!ok || v1 !== 1'b1 || s !== 32'd20) begin
      errors++; $display("FAIL mid_fresh_job: got valid=%b sum=%0d expected 1/20", v1, s);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    num_chunks = '0;
    sgn        = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    set_data(8'd0, 8'd0, 8'd0, 8'd0);
    test_reset;
    test_basic;
    test_signed;
    test_zero;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tree_adder_accum_ctrl.md
Name: tree_adder_accum_ctrl

Overview:
- Sequencer that reduces a long operand vector through one shared LANES-wide binary tree adder (instantiates binary_tree_adder internally).
- Streams the vector in chunks of LANES elements over a valid/ready input and accumulates the per-chunk tree sums into a 32-bit accumulator.
- Returns the final dot-reduction result over a valid/ready output.
- Sits between the operand buffer / multiplier array and the writeback path of the compute core.

Parameters:
- LANES, 8, elements per chunk; power of 2, >= 2 (elaboration $fatal otherwise).
- P, 8, bit width of each element.
- CNT_W, 16, width of the chunk-count field; constraint P+$clog2(LANES)+CNT_W <= 32 so the accumulator cannot overflow.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  start pulse; sampled only in IDLE.
- num_chunks_i  input  CNT_W  number of chunks in the job; latched on accepted start.
- signed_i  input  1  1 = elements and result are two's-complement; latched on accepted start.
- busy_o  output  1  high in any state except IDLE.
- in_valid_i  input  1  chunk valid.
- in_ready_o  output  1  chunk ready.
- in_data_i  input  P x LANES  unpacked array of LANES elements, P bits each.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  result accepted by consumer.
- out_sum_o  output  32  accumulated result.

Behaviour:
- Reset (async, any state, including mid-job): state=IDLE; accumulator, stage register, chunk counter, latched config all 0; busy_o=0, in_ready_o=0, out_valid_o=0, out_sum_o=0. Any in-flight job is discarded.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE: start_i=1 latches num_chunks_i and signed_i, clears the accumulator and stage-valid, and sets chunk counter = num_chunks_i.
  - num_chunks_i=0 -> DONE with sum 0; out_valid_o rises next cycle.
  - Otherwise -> ACCUM.
- ACCUM: in_ready_o=1.
  - Transfer occurs iff in_valid_i & in_ready_o.
  - Each transfer decrements the counter and registers the tree sum into a one-entry stage register (stage_valid=1).
  - A cycle with stage_valid=1 adds the extended stage value into the accumulator. The stage register and accumulator update concurrently, so full throughput is one chunk per cycle.
  - On the transfer that brings the counter to 0 -> DRAIN.
  - in_valid_i gaps stall without corrupting state.
- DRAIN: in_ready_o=0; the final stage value is added; -> DONE.
- DONE: out_valid_o=1 and out_sum_o=accumulator, both held stable until out_valid_o & out_ready_i; then -> IDLE.
- Handshake timing:
  - out_valid_o never drops without a handshake.
  - A start_i asserted in any non-IDLE state, including the DONE handshake cycle, is ignored; a new job needs start_i in IDLE.
- Width rule:
  - Tree output is P+$clog2(LANES) bits.
  - signed job: sign-extended to 32. Unsigned job: zero-extended to 32.
  - Accumulation is mod 2^32; no overflow is possible under the parameter constraint.
- Latency: last chunk transfer at cycle t -> out_valid_o high at t+2.
- in_ready_o is 0 in IDLE, DRAIN and DONE; data presented there is not consumed.

Test Plan:
- LANES=4, P=8, unsigned, num_chunks=3, each chunk {1,2,3,4}, in_valid_i held high -> three transfers on consecutive cycles; out_sum_o=30; out_valid_o two cycles after the third transfer.
- Signed, num_chunks=2, chunks all 0xFF (-1) -> out_sum_o=0xFFFFFFF8. The same job unsigned -> out_sum_o=2040 (0x7F8).
- num_chunks=0 start -> no in_ready_o pulse; out_valid_o next cycle with out_sum_o=0; busy_o drops after the handshake.
- Backpressure:
  - in_valid_i toggled 1/0 on a 4-chunk job -> correct sum; each gap cycle adds no transfer.
  - Then out_ready_i held low for 5 cycles -> out_valid_o/out_sum_o stable, in_ready_o=0, start_i pulses ignored.
- start_i asserted in the same cycle as the DONE handshake -> ignored; start_i next cycle (IDLE) launches a new job whose result excludes prior data.
- rst asserted asynchronously mid-ACCUM after 2 of 5 chunks -> all outputs 0 immediately. A fresh 1-chunk {5,5,5,5} job after reset -> out_sum_o=20.
